// File: rtl/aes_state_io.sv
// AES state-matrix bus controller: load 4 columns, kick the round engine, unload.
// Optional run timeout with sticky err under `AES_STATE_IO_TIMEOUT_EN.
module aes_state_io #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [31:0]  mat_col_in,
  output logic [1:0]   mat_input_idx,
  output logic         mat_input_row_col,
  output logic         mat_write_enable,
  output logic [1:0]   mat_output_idx,
  output logic         mat_output_row_col,
  input  logic [31:0]  mat_out,
  output logic         start,
  input  logic         done,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         err
);

  if (TO_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, UNLOAD, OUT
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] buf_q, buf_d;
  logic [127:0] out_q, out_d;
  logic         first_q, first_d;
  logic [6:0]   sel;

  // column 0 lives in the top word
  assign sel = {~cnt_q, 5'd0};

`ifdef AES_STATE_IO_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
  logic            to_hit;
  assign to_hit = (to_q == TO_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    out_d   = out_q;
    first_d = 1'b0;
`ifdef AES_STATE_IO_TIMEOUT_EN
    to_d    = to_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = in_block;
          cnt_d   = 2'd0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = RUN;
          first_d = 1'b1;
`ifdef AES_STATE_IO_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      RUN: begin
`ifdef AES_STATE_IO_TIMEOUT_EN
        to_d = to_q + 1'b1;
`endif
        if (!first_q && done) begin
          cnt_d   = 2'd0;
          state_d = UNLOAD;
        end
`ifdef AES_STATE_IO_TIMEOUT_EN
        else if (to_hit) begin
          cnt_d   = 2'd0;
          state_d = UNLOAD;
          err_d   = 1'b1;
        end
`endif
      end
      UNLOAD: begin
        cnt_d = cnt_q + 2'd1;
        out_d[sel +: 32] = mat_out;
        if (cnt_q == 2'd3) state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      buf_q   <= '0;
      out_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      first_q <= first_d;
    end
  end

`ifdef AES_STATE_IO_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready           = (state_q == IDLE);
  assign mat_write_enable   = (state_q == LOAD);
  assign mat_input_idx      = mat_write_enable ? cnt_q : 2'd0;
  assign mat_col_in         = buf_q[sel +: 32];
  assign mat_output_idx     = (state_q == UNLOAD) ? cnt_q : 2'd0;
  assign mat_input_row_col  = 1'b1;
  assign mat_output_row_col = 1'b1;
  assign start              = (state_q == RUN) && first_q;
  assign out_valid          = (state_q == OUT);
  assign out_block          = out_q;

endmodule

// File: tb/tb_aes_state_io.sv
// Bench for aes_state_io: matrix model, scripted engine, block scoreboard.
// Timeout scenario is built when AES_STATE_IO_TIMEOUT_EN is defined.
module tb_aes_state_io;

`ifdef AES_STATE_IO_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [31:0]  mat_col_in;
  logic [1:0]   mat_input_idx;
  logic         mat_input_row_col;
  logic         mat_write_enable;
  logic [1:0]   mat_output_idx;
  logic         mat_output_row_col;
  logic [31:0]  mat_out;
  logic         start;
  logic         done;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         err;

  aes_state_io #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .mat_col_in(mat_col_in), .mat_input_idx(mat_input_idx),
    .mat_input_row_col(mat_input_row_col),
    .mat_write_enable(mat_write_enable),
    .mat_output_idx(mat_output_idx),
    .mat_output_row_col(mat_output_row_col),
    .mat_out(mat_out), .start(start), .done(done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0] mat [4];
  always @(posedge clk)
    if (mat_write_enable) mat[mat_input_idx] <= mat_col_in;
  assign mat_out = mat[mat_output_idx];

  int checks = 0;
  int errors = 0;
  logic [127:0] sbq [$];
  logic err_exp = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset_n) sbq.delete();
    else begin
      if (in_valid && in_ready) sbq.push_back(in_block);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk("sb_pop_empty", 1, 0);
        else chk("sb_block", out_block, sbq.pop_front());
      end
    end
  end

  task automatic reset_checks();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_start", start, 0);
    chk("rst_we", mat_write_enable, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_out_block", out_block, 0);
    chk("rst_widx", mat_input_idx, 0);
    chk("rst_ridx", mat_output_idx, 0);
    chk("rst_rc", {mat_input_row_col, mat_output_row_col}, 2'b11);
  endtask

  // Accept, load, start, wait gap cycles, done for hold cycles, unload.
  task automatic do_block(input logic [127:0] blk, input bit early,
                          input int gap, input int hold, input int bp,
                          input bit nodone);
    logic [127:0] b;
    b = blk;
    chk("acc_ready", in_ready, 1);
    in_block = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ld_we", mat_write_enable, 1);
      chk("ld_idx", mat_input_idx, i[1:0]);
      chk("ld_col", mat_col_in, b[127-32*i -: 32]);
      chk("ld_start", start, 0);
      chk("ld_ready", in_ready, 0);
      done = early && (i == 1);
      tick();
    end
    done = early;
    chk("start_hi", start, 1);
    chk("start_we", mat_write_enable, 0);
    tick();
    done = 1'b0;
    for (int i = 0; i < gap; i++) begin
      chk("run_start", start, 0);
      chk("run_ov", out_valid, 0);
      chk("run_ready", in_ready, 0);
      tick();
    end
    if (!nodone) done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      done = !nodone && (i + 1 < hold);
      chk("ul_idx", mat_output_idx, i[1:0]);
      chk("ul_ov", out_valid, 0);
    end
    done = 1'b0;
    tick();
    chk("ov_hi", out_valid, 1);
    chk("ov_blk", out_block, b);
    chk("err", err, err_exp);
    in_block = ~b;
    in_valid = (bp > 0);
    for (int i = 0; i < bp; i++) begin
      tick();
      chk("bp_ov", out_valid, 1);
      chk("bp_blk", out_block, b);
      chk("bp_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_ov", out_valid, 0);
    chk("post_ready", in_ready, 1);
    chk("post_hold", out_block, b);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_block  = '0;
    done      = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    reset_n = 1'b1;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("spur_ready", in_ready, 1);
    chk("spur_ov", out_valid, 0);

    do_block(128'h00112233445566778899aabbccddeeff, 0, 2, 1, 0, 0);
    do_block(128'hdeadbeef0123456789abcdeffedcba98, 0, 1, 1, 10, 0);
    do_block(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1, 0, 3, 0, 0);
    repeat (3) begin
      tick();
      chk("one_ul_ov", out_valid, 0);
      chk("one_ul_ready", in_ready, 1);
    end

    in_block = 128'hcafef00d_11112222_33334444_55556666;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    repeat (2) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    chk("mid_ridx", mat_output_idx, 2);
    reset_n = 1'b0;
    #1;
    reset_checks();
    tick();
    reset_n = 1'b1;
    tick();
    do_block(128'h13579bdf_2468ace0_fedcba98_76543210, 0, 4, 1, 0, 0);

`ifdef AES_STATE_IO_TIMEOUT_EN
    err_exp = 1'b1;
    do_block(128'h0badc0de_0badc0de_12345678_9abcdef0, 0, 6, 0, 0, 1);
    do_block(128'h55aa55aa_aa55aa55_00ff00ff_ff00ff00, 0, 1, 1, 0, 0);
    chk("err_sticky", err, 1);
    reset_n = 1'b0;
    #1;
    chk("err_rst", err, 0);
    tick();
    reset_n = 1'b1;
    tick();
`endif

    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_state_io.md
Name: aes_state_io

Overview:
- Bus-side controller for the AES 4x4 state matrix store (the block holding state[row][col] bytes with column/row write and read ports).
- Accepts a 128-bit block over a valid/ready handshake and writes it into the matrix one column per cycle.
- Pulses `start` to the round engine and waits for `done`.
- Reads the matrix back one column per cycle and presents the 128-bit result over a valid/ready handshake.
- Sits between the top-level block interface and the matrix/round-engine pair.

Parameters:
- TIMEOUT_CYCLES, 64: maximum RUN-state cycles before forced unload. Used only with the optional feature.
- TO_W, 8: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input block valid
- in_ready  out  1  controller can accept a block
- in_block  in  128  plaintext/state block; [127:96] = column 0, MSB byte = row 0
- mat_col_in  out  32  column data to matrix write port, {row0,row1,row2,row3}
- mat_input_idx  out  2  column index for write
- mat_input_row_col  out  1  always 1 (column access)
- mat_write_enable  out  1  matrix write strobe
- mat_output_idx  out  2  column index for read
- mat_output_row_col  out  1  always 1 (column access)
- mat_out  in  32  combinational read data from matrix
- start  out  1  one-cycle pulse to round engine
- done  in  1  round engine finished
- out_valid  out  1  result block valid
- out_ready  in  1  downstream accepts result
- out_block  out  128  result block, same byte ordering as in_block
- err  out  1  sticky timeout flag; tied 0 without the optional feature

Behaviour:
- Clock and reset: one clock, clk. Reset_n is asynchronous, active-low.
- On reset assertion:
  - State goes to IDLE; column counter is 0.
  - in_block buffer and out_block are cleared to 0.
  - start=0, mat_write_enable=0, out_valid=0, err=0.
  - mat_*_idx=0; mat_*_row_col=1.
  - in_ready=1 (decoded from IDLE), but no transfer occurs while reset_n=0.
- States: IDLE, LOAD, RUN, UNLOAD, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture in_block into an internal buffer, clear the counter, go to LOAD.
- LOAD, 4 cycles:
  - mat_write_enable=1, mat_input_idx=cnt.
  - mat_col_in = buffer[127-32*cnt -: 32].
  - When cnt==3: go to RUN.
- RUN:
  - start=1 in the first RUN cycle only.
  - done is ignored in the cycle start is high and in all other states.
  - On done in any later RUN cycle: clear cnt, go to UNLOAD.
- UNLOAD, 4 cycles:
  - mat_output_idx=cnt.
  - out_block[127-32*cnt -: 32] <= mat_out at the clock edge.
  - When cnt==3: go to OUT.
- OUT:
  - out_valid=1. out_block is stable while out_valid is high.
  - On out_ready: go to IDLE.
  - out_block holds its value after the handshake until the next UNLOAD overwrites it.
- Latency:
  - Accept at edge T; column writes occur in cycles T+1..T+4; start is high in cycle T+5.
  - done sampled at edge D; reads occur in cycles D+1..D+4; out_valid rises in cycle D+5.
- Boundary and illegal conditions:
  - in_ready=0 outside IDLE; in_valid is ignored there.
  - out_ready while out_valid=0 has no effect.
  - done held high for multiple cycles triggers exactly one unload.
  - Reset mid-operation aborts immediately to the reset state. The matrix contents are not cleared by this block.
- The counter is 2 bits and wraps 3->0 on state exit.

Optional Feature:
- Macro: AES_STATE_IO_TIMEOUT_EN.
- With the macro defined:
  - A TO_W-bit counter clears on RUN entry and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES without done, the controller goes to UNLOAD anyway and sets err=1.
  - err is sticky; it clears only on reset.
- Without the macro:
  - No timeout counter; RUN waits indefinitely.
  - err is constant 0.

Test Plan:
- Basic load:
  - Stimulus: reset, then in_block=128'h00112233445566778899aabbccddeeff with in_valid.
  - Required: cycles T+1..T+4 show write_enable=1, idx 0..3, col_in = 32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff.
  - Required: start is high only in cycle T+5.
- Identity round trip:
  - Stimulus: engine stub asserts done 3 cycles after start, matrix unchanged.
  - Required: out_valid in cycle D+5 with out_block == in_block; mat_output_idx steps 0..3 during UNLOAD.
- Backpressure:
  - Stimulus: out_ready held 0 for 10 cycles, and in_valid kept high throughout.
  - Required: out_valid and out_block stay stable; in_ready=0; no second load occurs until after the out handshake, then the next block is accepted.
- Done handling:
  - Stimulus: done pulsed in the start cycle and during LOAD, then held high for 3 RUN cycles.
  - Required: early pulses are ignored; exactly one UNLOAD sequence occurs.
- Reset mid-UNLOAD:
  - Stimulus: assert reset_n=0 at cnt==2 of UNLOAD.
  - Required: outputs immediately take reset values; after release, in_ready=1 and a new block loads normally.
- Timeout (AES_STATE_IO_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: done never asserted.
  - Required: UNLOAD begins after 8 RUN cycles, err=1 and stays 1 across the next block until reset.
